fuzz_response_compactor: RTL and testbench

- Synthesizable response-side companion to the fuzz stimulus driver: consumes the DUT's flat output bus once per clock and folds it into a 32-bit MISR signature.
- Hardware regression runs then compare one signature word per seed instead of full CYCLE traces.
- Sits between the DUT's flat output and the result-readout logic; start/length come from the run controller.

---
 rtl/fuzz_response_compactor.sv | 125 ++++++++++++
 tb/tb_fuzz_response_compactor.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_response_compactor.sv
// fuzz_response_compactor: folds a wide DUT output bus into a 32-bit MISR
// signature over a programmed number of valid samples, then offers the
// signature and the elapsed RUN cycle count through a valid/ready handshake.
module fuzz_response_compactor #(
  parameter int unsigned DATA_W = 330,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       num_samples,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_sig,
  output logic [31:0]       res_cycles
);

  localparam int unsigned NCHUNK = (DATA_W + 31) / 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sig_q, sig_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] cyc_q, cyc_d;

  logic [NCHUNK*32-1:0] padded;
  logic [31:0]          folded;
  logic [31:0]          misr_next;

  // XOR-fold the bus into one word; the top chunk is zero-padded.
  always_comb begin
    padded              = '0;
    padded[DATA_W-1:0]  = data_in;
    folded              = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      folded = folded ^ padded[k*32 +: 32];
    end
    misr_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : '0) ^ folded;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      rem_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      rem_q   <= rem_d;
      cyc_q   <= cyc_d;
    end
  end

  // Next-state selection; abort takes priority over data_valid and res_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (data_valid && (rem_q == 32'd1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (abort || res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: load on accepted start, step/count while running.
  always_comb begin
    sig_d = sig_q;
    rem_d = rem_q;
    cyc_d = cyc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sig_d = SEED;
          rem_d = num_samples;
          cyc_d = '0;
        end
      end
      S_RUN: begin
        if (!abort) begin
          cyc_d = cyc_q + 32'd1;
          if (data_valid) begin
            sig_d = misr_next;
            rem_d = rem_q - 32'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; result registers hold until the next start.
  always_comb begin
    busy       = (state_q == S_RUN);
    res_valid  = (state_q == S_DONE);
    res_sig    = sig_q;
    res_cycles = cyc_q;
  end

endmodule

// File: tb/tb_fuzz_response_compactor.sv
// Self-checking bench for fuzz_response_compactor: directed scenarios with
// literal signatures plus randomized traffic checked every cycle against a
// queue-based reference model.
module tb_fuzz_response_compactor;

  localparam int unsigned DW   = 330;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   num_samples;
  logic          abort;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_sig;
  logic [31:0]   res_cycles;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  fuzz_response_compactor #(
    .DATA_W(DW),
    .POLY  (POLY),
    .SEED  (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_samples(num_samples),
    .abort      (abort),
    .data_in    (data_in),
    .data_valid (data_valid),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sig    (res_sig),
    .res_cycles (res_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bit i of the bus lands in folded bit i mod 32.
  function automatic logic [31:0] fold(input logic [DW-1:0] d);
    logic [31:0] f = '0;
    for (int i = 0; i < int'(DW); i++) f[i % 32] = f[i % 32] ^ d[i];
    return f;
  endfunction

  function automatic logic [31:0] signature(input logic [DW-1:0] s[$]);
    logic [31:0] r = SEED;
    foreach (s[i]) r = (r << 1) ^ (r[31] ? POLY : 32'h0) ^ fold(s[i]);
    return r;
  endfunction

  // Behavioural model: run/done flags, sample queue, cycle count.
  bit            m_run = 0, m_done = 0, m_known = 0;
  longint        m_rem = 0;
  logic [31:0]   m_cyc = '0;
  logic [31:0]   m_sig = '0;
  logic [DW-1:0] m_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_done = 0; m_rem = 0; m_cyc = '0; m_sig = SEED; m_known = 1;
      m_q.delete();
    end else if (m_run) begin
      if (abort) m_run = 0;
      else begin
        m_cyc = m_cyc + 32'd1;
        if (data_valid) begin
          m_q.push_back(data_in);
          m_rem--;
          if (m_rem == 0) begin
            m_run = 0; m_done = 1; m_known = 1;
            m_sig = signature(m_q);
          end
        end
      end
    end else if (m_done) begin
      if (abort || res_ready) m_done = 0;
    end else if (start) begin
      m_q.delete();
      m_cyc = '0;
      m_rem = longint'(num_samples);
      m_known = 0;
      if (num_samples == 0) begin
        m_done = 1; m_known = 1; m_sig = SEED;
      end else m_run = 1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_run});
      chk("res_valid", {31'b0, res_valid}, {31'b0, m_done});
      if (m_known) begin
        chk("res_sig", res_sig, m_sig);
        chk("res_cycles", res_cycles, m_cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input logic [31:0] n);
    @(negedge clk);
    start = 1'b1; num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic await_result(input string name, input logic [31:0] esig,
                              input logic [31:0] ecyc, input int max);
    int n = 0;
    while (!res_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, {31'b0, res_valid}, 32'd1);
    chk({name, "_sig"}, res_sig, esig);
    chk({name, "_cycles"}, res_cycles, ecyc);
    data_valid = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("accept_idle", {31'b0, res_valid}, 32'd0);
  endtask

  task automatic single(input string name, input logic [DW-1:0] d, input logic [31:0] esig);
    start_run(1);
    data_in = d; data_valid = 1'b1;
    await_result(name, esig, 32'd1, 20);
    accept();
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] zq[$];
    logic [351:0]  wide;
    int unsigned   pat[5] = '{1, 0, 0, 1, 1};

    rst = 1'b1; start = 1'b0; num_samples = '0; abort = 1'b0;
    data_in = '0; data_valid = 1'b0; res_ready = 1'b0;

    // Pin the reference model with hand-computed values.
    zq.push_back('0);
    chk("model_sig1", signature(zq), 32'hFB3EE249);
    zq.push_back('0);
    chk("model_sig2", signature(zq), 32'hF2BCD925);
    zq.push_back('0);
    chk("model_sig3", signature(zq), 32'hE1B8AFFD);
    d = '0; d[329] = 1'b1;
    chk("model_fold_top", fold(d), 32'h00000200);

    repeat (2) @(negedge clk);
    chk("reset_sig", res_sig, SEED);
    chk("reset_cycles", res_cycles, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Three zero samples, continuous valid.
    start_run(3);
    data_in = '0; data_valid = 1'b1;
    await_result("zero3", 32'hE1B8AFFD, 32'd3, 20);
    accept();

    // Fold cancellation and single-bit difference.
    d = '0; d[0] = 1'b1; d[32] = 1'b1;
    single("cancel", d, 32'hFB3EE249);
    d = '0; d[0] = 1'b1;
    single("bit0", d, 32'hFB3EE248);
    d = '0; d[329] = 1'b1;
    single("bit329", d, 32'hFB3EE049);

    // Stalled sampling: valid pattern 1,0,0,1,1.
    start_run(3);
    data_in = '0;
    foreach (pat[i]) begin
      data_valid = pat[i][0];
      @(negedge clk);
    end
    await_result("stall", 32'hE1B8AFFD, 32'd5, 2);
    accept();

    // Zero-length run: result one cycle after start, held under backpressure.
    start_run(0);
    chk("zero_len_valid", {31'b0, res_valid}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, res_valid}, 32'd1);
      chk("hold_sig", res_sig, 32'hFFFFFFFF);
      chk("hold_cycles", res_cycles, 32'd0);
    end
    start = 1'b1; num_samples = 32'd2;
    accept();
    start = 1'b0;
    chk("start_in_handshake", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("start_not_queued", {31'b0, busy}, 32'd0);

    // Abort during RUN, then a clean run.
    start_run(5);
    data_in = '0; data_valid = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; data_valid = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_result", {31'b0, res_valid}, 32'd0);
    end
    start_run(1);
    data_valid = 1'b1;
    await_result("after_abort", 32'hFB3EE249, 32'd1, 20);

    // Abort beats res_ready in DONE.
    abort = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; res_ready = 1'b0;
    chk("abort_done", {31'b0, res_valid}, 32'd0);

    // Same scenario using reset.
    start_run(5);
    data_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; data_valid = 1'b0;
    chk("rst_sig", res_sig, SEED);
    repeat (3) @(negedge clk);
    start_run(1);
    data_valid = 1'b1;
    await_result("after_rst", 32'hFB3EE249, 32'd1, 20);
    accept();

    // Randomized traffic checked by the model every cycle.
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 3) == 0);
      num_samples = $urandom_range(0, 6);
      abort       = ($urandom_range(0, 29) == 0);
      data_valid  = ($urandom_range(0, 9) < 6);
      res_ready   = ($urandom_range(0, 9) < 4);
      for (int k = 0; k < 11; k++) wide[k*32 +: 32] = $urandom;
      data_in = wide[DW-1:0];
    end

    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b1; data_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
